// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge: AHB-Lite slave turning single word transfers into APB3 accesses
module ahb_apb_bridge #(
    parameter int NSLV     = 4,
    parameter int SLOT_LSB = 12,
    parameter int PADDR_W  = 12,
    parameter int TIMEOUT  = 255
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               HSEL,
    input  logic [31:0]        HADDR,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic [1:0]         HTRANS,
    input  logic [31:0]        HWDATA,
    input  logic               HREADY,
    output logic               HREADYOUT,
    output logic               HRESP,
    output logic [31:0]        HRDATA,
    output logic [PADDR_W-1:0] PADDR,
    output logic [NSLV-1:0]    PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [31:0]        PWDATA,
    input  logic [31:0]        PRDATA,
    input  logic               PREADY,
    input  logic               PSLVERR
);
    typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2} state_t;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [NSLV-1:0] ONE = 1;
    state_t state_q, state_d;
    logic [3:0] slot_q, slot_d;
    logic [7:0] cnt_q, cnt_d;
    logic [PADDR_W-1:0] paddr_q, paddr_d;
    logic pwrite_q, pwrite_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [31:0] hrdata_q, hrdata_d;
    logic hreadyout_q, hreadyout_d;
    logic hresp_q, hresp_d;
    logic [NSLV-1:0] psel_q, psel_d;
    logic penable_q, penable_d;
    logic [3:0] slot_in;
    logic accept, bad;
    logic unused_ok;
    assign slot_in = HADDR[SLOT_LSB+3:SLOT_LSB];
    assign accept = HSEL & HREADY & HTRANS[1];
    assign bad = (32'(slot_in) >= NSLV) | (HSIZE != 3'b010);
    assign unused_ok = &{1'b0, HADDR, HTRANS[0]};
    assign HREADYOUT = hreadyout_q;
    assign HRESP = hresp_q;
    assign HRDATA = hrdata_q;
    assign PADDR = paddr_q;
    assign PSEL = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE = pwrite_q;
    assign PWDATA = pwdata_q;
    // next state, captured transfer attributes and registered bus outputs
    always_comb begin
        state_d = state_q;
        slot_d = slot_q;
        cnt_d = cnt_q;
        paddr_d = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        hrdata_d = hrdata_q;
        case (state_q)
            IDLE, DONE, ERR2: begin
                state_d = IDLE;
                if (accept) begin
                    paddr_d = HADDR[PADDR_W-1:0];
                    pwrite_d = HWRITE;
                    slot_d = slot_in;
                    state_d = bad ? ERR1 : HWRITE ? WDATA : SETUP;
                end
            end
            WDATA: begin
                pwdata_d = HWDATA;
                state_d = SETUP;
            end
            SETUP: begin
                cnt_d = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    hrdata_d = (!PSLVERR && !pwrite_q) ? PRDATA : hrdata_q;
                    state_d = PSLVERR ? ERR1 : DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    state_d = (cnt_q == TO_LAST) ? ERR1 : ACCESS;
                end
            end
            ERR1: state_d = ERR2;
            default: state_d = IDLE;
        endcase
        hreadyout_d = (state_d == IDLE) || (state_d == DONE) || (state_d == ERR2);
        hresp_d = (state_d == ERR1) || (state_d == ERR2);
        psel_d = (state_d == SETUP || state_d == ACCESS) ? ONE << slot_d : '0;
        penable_d = state_d == ACCESS;
    end
    // state and output registers; reset drops PSEL/PENABLE at once
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            slot_q <= '0;
            cnt_q <= '0;
            paddr_q <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            hrdata_q <= '0;
            hreadyout_q <= 1'b1;
            hresp_q <= 1'b0;
            psel_q <= '0;
            penable_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q <= slot_d;
            cnt_q <= cnt_d;
            paddr_q <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            hrdata_q <= hrdata_d;
            hreadyout_q <= hreadyout_d;
            hresp_q <= hresp_d;
            psel_q <= psel_d;
            penable_q <= penable_d;
        end
    end
endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb_ahb_apb_bridge: directed AHB transfers with response and APB scoreboards
module tb_ahb_apb_bridge;
    logic HCLK, HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0] HADDR, HWDATA, HRDATA, PWDATA, PRDATA;
    logic [2:0] HSIZE;
    logic [1:0] HTRANS;
    logic [11:0] PADDR;
    logic [3:0] PSEL;
    typedef struct { logic err; bit chk; logic [31:0] rd; int waits; } rexp_t;
    typedef struct { logic [11:0] paddr; logic [3:0] psel; logic wr; logic [31:0] wd; int acc; } aexp_t;
    rexp_t rq[$];
    aexp_t aq[$];
    aexp_t cur;
    rexp_t re;
    int n_chk = 0, n_fail = 0;
    int lo = 0, rc = 0, acc = 0, wait_n = 0, acc_cnt = 0;
    bit active = 0, stuck = 0, slv_err = 0;
    logic [31:0] rdata;

    ahb_apb_bridge #(.NSLV(4), .SLOT_LSB(12), .PADDR_W(12), .TIMEOUT(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial HCLK = 0;
    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;
    assign PRDATA = rdata;
    assign PSLVERR = slv_err;
    assign PREADY = !stuck && (acc_cnt >= wait_n);

    // slave model: count PREADY-low ACCESS cycles
    always @(posedge HCLK) acc_cnt <= (PSEL != 0 && PENABLE && !PREADY) ? acc_cnt + 1 : 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic exp_r(input logic err, input bit c, input logic [31:0] rd, input int w);
        rexp_t e;
        e.err = err; e.chk = c; e.rd = rd; e.waits = w;
        rq.push_back(e);
    endtask

    task automatic exp_a(input logic [11:0] pa, input logic [3:0] ps, input logic wr, input logic [31:0] wd, input int a);
        aexp_t e;
        e.paddr = pa; e.psel = ps; e.wr = wr; e.wd = wd; e.acc = a;
        aq.push_back(e);
    endtask

    task automatic apb_cmp(input string ph);
        chk({"apb_paddr_", ph}, {20'd0, PADDR}, {20'd0, cur.paddr});
        chk({"apb_psel_", ph}, {28'd0, PSEL}, {28'd0, cur.psel});
        chk({"apb_pwrite_", ph}, {31'd0, PWRITE}, {31'd0, cur.wr});
        if (cur.wr) chk({"apb_pwdata_", ph}, PWDATA, cur.wd);
    endtask

    // AHB response monitor
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            lo = 0; rc = 0;
        end else if (!HREADYOUT) begin
            lo++; rc += int'(HRESP);
        end else if (lo != 0) begin
            rc += int'(HRESP);
            if (rq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL resp_unexp: got completion expected none");
            end else begin
                re = rq.pop_front();
                chk("wait_states", lo, re.waits);
                chk("hresp_final", {31'd0, HRESP}, {31'd0, re.err});
                chk("hresp_cycles", rc, re.err ? 2 : 0);
                if (re.chk) chk("hrdata", HRDATA, re.rd);
            end
            lo = 0; rc = 0;
        end
    end

    // APB monitor
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            active = 0;
        end else if (PSEL != 0 && !PENABLE) begin
            n_chk++;
            if (aq.size() == 0) begin
                n_fail++;
                $display("FAIL apb_unexp: got psel=%b expected none", PSEL);
            end else begin
                cur = aq.pop_front(); active = 1; acc = 0;
                apb_cmp("setup");
            end
        end else if (PSEL != 0 && PENABLE) begin
            acc++;
            if (active) apb_cmp("access");
        end else if (active) begin
            active = 0;
            chk("apb_access_cycles", acc, cur.acc);
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge HCLK);
        while (!HREADYOUT && n < 50) begin
            @(negedge HCLK);
            n++;
        end
        if (!HREADYOUT) begin
            n_chk++; n_fail++;
            $display("FAIL hready_timeout: got HREADYOUT=0 expected 1 within 50 cycles");
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic ahb(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] wd, input bit last);
        HSEL = 1; HTRANS = 2'b10; HADDR = a; HWRITE = w; HSIZE = s;
        wait_ready();
        HWDATA = wd;
        if (last) begin
            HSEL = 0; HTRANS = 2'b00;
        end
    endtask

    initial begin
        HSEL = 0; HTRANS = 0; HADDR = 0; HWRITE = 0; HSIZE = 3'b010; HWDATA = 0; rdata = 0;
        HRESETn = 0;
        repeat (3) @(negedge HCLK);
        #1 HRESETn = 1;
        @(negedge HCLK);
        chk("rst_hreadyout", {31'd0, HREADYOUT}, 1);
        chk("rst_hresp", {31'd0, HRESP}, 0);
        chk("rst_hrdata", HRDATA, 0);
        chk("rst_paddr", {20'd0, PADDR}, 0);
        chk("rst_psel", {28'd0, PSEL}, 0);
        chk("rst_penable", {31'd0, PENABLE}, 0);
        chk("rst_pwrite", {31'd0, PWRITE}, 0);
        chk("rst_pwdata", PWDATA, 0);
        @(posedge HCLK); #1;
        // read slot 1, fast slave
        rdata = 32'hDEAD_BEEF;
        exp_r(0, 1, 32'hDEAD_BEEF, 2); exp_a(12'h004, 4'b0010, 0, 0, 1);
        ahb(32'h0000_1004, 0, 3'b010, 0, 1); wait_ready();
        // write slot 0, three PREADY-low cycles
        wait_n = 3;
        exp_r(0, 0, 0, 6); exp_a(12'h010, 4'b0001, 1, 32'h1234_5678, 4);
        ahb(32'h0000_0010, 1, 3'b010, 32'h1234_5678, 1); wait_ready();
        wait_n = 0;
        // slave error on read slot 2
        slv_err = 1; rdata = 32'hBAD0_BAD0;
        exp_r(1, 1, 32'hDEAD_BEEF, 3); exp_a(12'h008, 4'b0100, 0, 0, 1);
        ahb(32'h0000_2008, 0, 3'b010, 0, 1); wait_ready();
        slv_err = 0;
        // unmapped slot
        exp_r(1, 1, 32'hDEAD_BEEF, 1);
        ahb(32'h0000_5000, 0, 3'b010, 0, 1); wait_ready();
        // byte size
        exp_r(1, 1, 32'hDEAD_BEEF, 1);
        ahb(32'h0000_0000, 1, 3'b000, 32'h0000_00FF, 1); wait_ready();
        // timeout on slot 3
        stuck = 1;
        exp_r(1, 1, 32'hDEAD_BEEF, 6); exp_a(12'h000, 4'b1000, 0, 0, 4);
        ahb(32'h0000_3000, 0, 3'b010, 0, 1); wait_ready();
        stuck = 0;
        // read slot 2 recovers
        rdata = 32'hCAFE_F00D;
        exp_r(0, 1, 32'hCAFE_F00D, 2); exp_a(12'h00C, 4'b0100, 0, 0, 1);
        ahb(32'h0000_200C, 0, 3'b010, 0, 1); wait_ready();
        // back-to-back write then read
        rdata = 32'h0BAD_F00D;
        exp_r(0, 0, 0, 3); exp_a(12'h020, 4'b0010, 1, 32'hA5A5_5A5A, 1);
        exp_r(0, 1, 32'h0BAD_F00D, 2); exp_a(12'h030, 4'b1000, 0, 0, 1);
        ahb(32'h0000_1020, 1, 3'b010, 32'hA5A5_5A5A, 0);
        ahb(32'h0000_3030, 0, 3'b010, 0, 1); wait_ready();
        // reset asserted during ACCESS
        stuck = 1;
        exp_a(12'h040, 4'b0001, 0, 0, 0);
        ahb(32'h0000_0040, 0, 3'b010, 0, 1);
        begin
            int n = 0;
            @(negedge HCLK);
            while (!PENABLE && n < 20) begin
                @(negedge HCLK);
                n++;
            end
        end
        chk("rst_reach_access", {31'd0, PENABLE}, 1);
        #3 HRESETn = 0;
        #1;
        chk("midrst_psel", {28'd0, PSEL}, 0);
        chk("midrst_penable", {31'd0, PENABLE}, 0);
        chk("midrst_hreadyout", {31'd0, HREADYOUT}, 1);
        @(negedge HCLK);
        #1 HRESETn = 1; stuck = 0;
        @(negedge HCLK);
        chk("postrst_hreadyout", {31'd0, HREADYOUT}, 1);
        chk("postrst_hrdata", HRDATA, 0);
        chk("postrst_psel", {28'd0, PSEL}, 0);
        @(posedge HCLK); #1;
        rdata = 32'h1122_3344;
        exp_r(0, 1, 32'h1122_3344, 2); exp_a(12'h008, 4'b0010, 0, 0, 1);
        ahb(32'h0000_1008, 0, 3'b010, 0, 1); wait_ready();
        repeat (3) @(negedge HCLK);
        chk("resp_queue_left", rq.size(), 0);
        chk("apb_queue_left", aq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_apb_bridge.md
# ahb_apb_bridge

AHB-Lite slave that converts single word transfers from the processor's AHB master into APB3 accesses to the peripheral slots, one at a time. It sits directly downstream of the AHB master, on the peripheral branch of the bus, and feeds the APB peripherals (GPIO, timer, UART). It inserts AHB wait states until the APB access completes. It returns a two-cycle AHB ERROR response on an APB slave error, an unmapped slot, an unsupported size or a PREADY timeout.

## Interface
- NSLV, 4: number of APB slots (1..16); PSEL is NSLV bits wide.
- SLOT_LSB, 12: slot index is HADDR[SLOT_LSB+3:SLOT_LSB].
- PADDR_W, 12: PADDR = HADDR[PADDR_W-1:0].
- TIMEOUT, 255: maximum ACCESS cycles without PREADY (1..255).

Ports:
- HCLK  in  1  clock; single clock domain.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL  in  1  bridge selected by the AHB decoder.
- HADDR  in  32  AHB address.
- HWRITE  in  1  AHB direction.
- HSIZE  in  3  AHB size; only 3'b010 is supported.
- HTRANS  in  2  AHB transfer type.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready (muxed HREADYOUT).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  1 = ERROR.
- HRDATA  out  32  registered read data.
- PADDR  out  PADDR_W  APB address.
- PSEL  out  NSLV  one-hot slot select.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  selected slave read data (muxed externally).
- PREADY  in  1  selected slave ready.
- PSLVERR  in  1  selected slave error.

## Operation
- Accept condition: HSEL & HREADY & HTRANS[1], sampled at the clock edge, in states IDLE, DONE or ERR2.
  - On accept, register the address, HWRITE, the slot index and the size check.
  - If HTRANS is IDLE or BUSY in DONE or ERR2, go to IDLE.
  - HBURST is not an input. SEQ beats are treated like NONSEQ; each beat is a separate APB access.
- State IDLE: HREADYOUT=1, HRESP=0, no APB activity.
- On accept:
  - Slot >= NSLV, or HSIZE != 3'b010: go to ERR1. No APB access occurs.
  - Write: go to WDATA.
  - Read: go to SETUP.
- State WDATA (HREADYOUT=0): capture HWDATA into PWDATA at the end of the cycle, then go to SETUP.
- State SETUP (HREADYOUT=0): PSEL[slot]=1, PENABLE=0. PADDR and PWRITE are valid. Go to ACCESS.
- State ACCESS (HREADYOUT=0): PSEL held, PENABLE=1. An 8-bit wait counter increments each cycle PREADY=0.
  - PREADY=1 & PSLVERR=0: for a read, HRDATA <= PRDATA; go to DONE.
  - PREADY=1 & PSLVERR=1: go to ERR1. HRDATA is unchanged.
  - PREADY=0 and counter == TIMEOUT-1: drop PSEL and PENABLE next cycle; go to ERR1.
- State DONE: HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0. Accept rules apply.
- State ERR1: HRESP=1, HREADYOUT=0. Go to ERR2.
- State ERR2: HRESP=1, HREADYOUT=1. Accept rules apply.
- Hold rules:
  - PADDR, PWRITE and PWDATA hold their last value when idle.
  - PSEL and PENABLE are 0 outside SETUP and ACCESS.
  - HRDATA holds until the next successful read.

## Timing
- Reset values: HREADYOUT=1; HRESP=0; HRDATA=0; PADDR=0; PSEL=0; PENABLE=0; PWRITE=0; PWDATA=0. State is IDLE and the wait counter is 0.
- Reset asserted mid-access: PSEL and PENABLE fall asynchronously and the state returns to IDLE. The APB access is abandoned.
- Read, PREADY=1 on the first ACCESS cycle:
  - Address phase in cycle 0.
  - SETUP in c1, ACCESS in c2.
  - c3: HREADYOUT=1 and HRDATA valid.
  - Result: 2 wait states.
- Write, PREADY=1 on the first ACCESS cycle:
  - WDATA in c1, SETUP in c2, ACCESS in c3, DONE in c4.
  - Result: 3 wait states.
- Each PREADY=0 cycle in ACCESS adds one wait state.
- Back-to-back transfers: an address phase presented in the DONE or ERR2 cycle is accepted in that same cycle. SETUP (read) or WDATA (write) follows with no idle cycle.
- Error response: HRESP=1 for exactly 2 cycles, with HREADYOUT 0 then 1.
- HREADYOUT is never 0 in IDLE.

## Test plan
- Read slot 1: HADDR=0x0000_1004, read, PREADY=1, PRDATA=0xDEAD_BEEF.
  - PSEL=4'b0010 and PADDR=0x004 in c1–c2; PENABLE=1 in c2 only.
  - c3: HREADYOUT=1, HRDATA=0xDEAD_BEEF.
- Write slot 0 with slow slave: HADDR=0x0000_0010, HWDATA=0x1234_5678, PREADY low for 3 ACCESS cycles.
  - PWDATA=0x1234_5678 stable from SETUP to the end of ACCESS; PWRITE=1.
  - HREADYOUT=1 exactly 7 cycles after the address phase.
- Errors:
  - PSLVERR=1 with PREADY=1: HRESP=1 for 2 cycles, HREADYOUT 0 then 1, HRDATA unchanged.
  - HADDR=0x0000_5000 with NSLV=4: same error response, PSEL never asserted.
  - HSIZE=3'b000 (byte): same error response, PSEL never asserted.
- Timeout: TIMEOUT=4, PREADY stuck low.
  - PSEL/PENABLE drop after 4 ACCESS cycles.
  - Error response follows.
  - The next read to slot 2 completes normally.
- Back-to-back and reset:
  - A write is followed immediately by a read, with the read address phase in the write's DONE cycle: the read goes to SETUP next cycle.
  - HRESETn pulsed low during ACCESS: PSEL=0 and PENABLE=0 immediately, HREADYOUT=1, state IDLE after release.
